// File: rtl/line_buffer_col.sv
// line_buffer_col
// Multi-line pixel buffer feeding the median-filter window. Keeps the last
// NUM_LINES image lines in dual-port RAM and, for every accepted pixel,
// presents one vertical column of NUM_LINES+1 pixels one cycle later.
// The RAM read is synchronous and the read registers double as the column
// output. The RAM write is deferred by one cycle, and a forwarding path covers
// a read of the address whose write is still pending (line length of one).
module line_buffer_col #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int NUM_LINES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sof,
    input  logic [ADDR_W-1:0]               line_len,
    input  logic [DATA_W-1:0]               din,
    input  logic                            din_valid,
    output logic [(NUM_LINES+1)*DATA_W-1:0] col_dout,
    output logic                            col_valid,
    output logic [ADDR_W-1:0]               col_x,
    output logic                            primed
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(NUM_LINES + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_LINES);

    // line storage: mem[0] is the most recent complete line
    logic [DATA_W-1:0] mem [NUM_LINES][DEPTH];

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] len_q_r;
    logic [CNT_W-1:0]  line_cnt_r;
    logic              primed_r;
    logic              col_valid_r;
    logic [ADDR_W-1:0] col_x_r;
    logic [DATA_W-1:0] din_r;
    logic [DATA_W-1:0] rd_r [NUM_LINES];
    logic              wr_pend_r;

    logic [ADDR_W-1:0] x_s;
    logic [ADDR_W-1:0] len_eff_s;
    logic [CNT_W-1:0]  cnt_eff_s;
    logic [ADDR_W-1:0] wr_ptr_nxt_s;
    logic [CNT_W-1:0]  line_cnt_nxt_s;
    logic              fwd_s;
    logic [DATA_W-1:0] wdata_s [NUM_LINES];

    // frame position for this cycle: a start-of-frame pulse takes effect before the pixel
    always_comb begin
        x_s            = wr_ptr_r;
        len_eff_s      = len_q_r;
        cnt_eff_s      = line_cnt_r;
        wr_ptr_nxt_s   = wr_ptr_r;
        line_cnt_nxt_s = line_cnt_r;
        if (sof) begin
            x_s       = {ADDR_W{1'b0}};
            len_eff_s = line_len - ADDR_W'(1);
            cnt_eff_s = {CNT_W{1'b0}};
        end else begin
            x_s       = wr_ptr_r;
            len_eff_s = len_q_r;
            cnt_eff_s = line_cnt_r;
        end
        if (din_valid) begin
            if (x_s == len_eff_s) begin
                wr_ptr_nxt_s = {ADDR_W{1'b0}};
                if (cnt_eff_s == CNT_FULL) begin
                    line_cnt_nxt_s = cnt_eff_s;
                end else begin
                    line_cnt_nxt_s = cnt_eff_s + CNT_W'(1);
                end
            end else begin
                wr_ptr_nxt_s   = x_s + ADDR_W'(1);
                line_cnt_nxt_s = cnt_eff_s;
            end
        end else begin
            wr_ptr_nxt_s   = x_s;
            line_cnt_nxt_s = cnt_eff_s;
        end
    end

    // deferred write data: line 0 takes the last pixel, line k takes line k-1's old value
    always_comb begin
        for (int k = 0; k < NUM_LINES; k++) begin
            if (k == 0) begin
                wdata_s[k] = din_r;
            end else begin
                wdata_s[k] = rd_r[k-1];
            end
        end
        fwd_s = wr_pend_r && (col_x_r == x_s);
    end

    // frame counters, column registers and RAM read registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {ADDR_W{1'b0}};
            len_q_r     <= {ADDR_W{1'b1}};
            line_cnt_r  <= {CNT_W{1'b0}};
            primed_r    <= 1'b0;
            col_valid_r <= 1'b0;
            col_x_r     <= {ADDR_W{1'b0}};
            din_r       <= {DATA_W{1'b0}};
            wr_pend_r   <= 1'b0;
            for (int k = 0; k < NUM_LINES; k++) begin
                rd_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            len_q_r     <= len_eff_s;
            line_cnt_r  <= line_cnt_nxt_s;
            primed_r    <= (line_cnt_nxt_s == CNT_FULL);
            col_valid_r <= din_valid && (cnt_eff_s == CNT_FULL);
            wr_pend_r   <= din_valid;
            if (din_valid) begin
                din_r   <= din;
                col_x_r <= x_s;
                for (int k = 0; k < NUM_LINES; k++) begin
                    rd_r[k] <= fwd_s ? wdata_s[k] : mem[k][x_s];
                end
            end
        end
    end

    // deferred cascade write at the previous pixel's address
    always_ff @(posedge clk) begin
        if (wr_pend_r) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                mem[k][col_x_r] <= wdata_s[k];
            end
        end
    end

    // column assembly: current pixel in the low slice, oldest line on top
    assign col_dout[DATA_W-1:0] = din_r;
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_col
        assign col_dout[(g+1)*DATA_W +: DATA_W] = rd_r[g];
    end

    assign col_valid = col_valid_r;
    assign col_x     = col_x_r;
    assign primed    = primed_r;

endmodule

// File: tb/tb_line_buffer_col.sv
// Directed testbench for line_buffer_col (DATA_W=8, ADDR_W=3, NUM_LINES=2).
module tb_line_buffer_col;

    logic        clk;
    logic        rst_n;
    logic        sof;
    logic [2:0]  line_len;
    logic [7:0]  din;
    logic        din_valid;
    logic [23:0] col_dout;
    logic        col_valid;
    logic [2:0]  col_x;
    logic        primed;

    int pass_cnt;
    int total_cnt;

    line_buffer_col #(.DATA_W(8), .ADDR_W(3), .NUM_LINES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof       (sof),
        .line_len  (line_len),
        .din       (din),
        .din_valid (din_valid),
        .col_dout  (col_dout),
        .col_valid (col_valid),
        .col_x     (col_x),
        .primed    (primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one clock cycle of stimulus; returns 1 time unit after the edge
    task automatic drive(input logic s, input logic v, input logic [7:0] d, input logic [2:0] len);
        sof       = s;
        din_valid = v;
        din       = d;
        line_len  = len;
        @(posedge clk);
        #1;
        sof       = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (col_valid !== 1'b0 || primed !== 1'b0 || col_x !== 3'd0 || col_dout !== 24'd0)
            $display("FAIL reset_state: valid=%b primed=%b x=%0d dout=%h, want 0 0 0 000000",
                     col_valid, primed, col_x, col_dout);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream(input int gap);
        logic        ev;
        logic [23:0] ed;
        logic [2:0]  ex;
        drive(1'b1, 1'b0, 8'd0, 3'd4);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, 8'(i), 3'd0);
            ev = (i >= 8);
            ex = 3'(i % 4);
            ed = {8'(i - 8), 8'(i - 4), 8'(i)};
            total_cnt++;
            if (col_valid !== ev)
                $display("FAIL stream%0d_valid px%0d: got %b want %b", gap, i, col_valid, ev);
            else pass_cnt++;
            total_cnt++;
            if (primed !== (i >= 7))
                $display("FAIL stream%0d_primed px%0d: got %b want %b", gap, i, primed, (i >= 7));
            else pass_cnt++;
            if (ev) begin
                total_cnt++;
                if (col_dout !== ed || col_x !== ex)
                    $display("FAIL stream%0d_col px%0d: got %h x=%0d want %h x=%0d",
                             gap, i, col_dout, col_x, ed, ex);
                else pass_cnt++;
            end
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b0, 8'hEE, 3'd0);
                total_cnt++;
                if (col_valid !== 1'b0)
                    $display("FAIL stream%0d_idle px%0d: valid got %b want 0", gap, i, col_valid);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_sof_midline();
        drive(1'b1, 1'b0, 8'd0, 3'd5);
        for (int i = 0; i < 13; i++) drive(1'b0, 1'b1, 8'(i), 3'd0);
        total_cnt++;
        if (col_valid !== 1'b1 || col_x !== 3'd2)
            $display("FAIL sof_pre: valid=%b x=%0d want 1 x=2", col_valid, col_x);
        else pass_cnt++;
        drive(1'b1, 1'b1, 8'd100, 3'd5);
        total_cnt++;
        if (col_valid !== 1'b0 || primed !== 1'b0 || col_x !== 3'd0)
            $display("FAIL sof_same_cycle: valid=%b primed=%b x=%0d want 0 0 0",
                     col_valid, primed, col_x);
        else pass_cnt++;
        for (int j = 1; j <= 10; j++) begin
            drive(1'b0, 1'b1, 8'(100 + j), 3'd0);
            total_cnt++;
            if (col_valid !== (j == 10))
                $display("FAIL sof_refill_valid px%0d: got %b want %b", j, col_valid, (j == 10));
            else pass_cnt++;
        end
        total_cnt++;
        if (col_dout !== {8'd100, 8'd105, 8'd110} || col_x !== 3'd0)
            $display("FAIL sof_refill_col: got %h x=%0d want 64696e x=0", col_dout, col_x);
        else pass_cnt++;
    endtask

    task automatic test_max_len();
        drive(1'b1, 1'b0, 8'd0, 3'd0);
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'b1, 8'(50 + i), 3'd0);
            total_cnt++;
            if (col_x !== 3'(i % 8) || primed !== (i >= 15))
                $display("FAIL maxlen px%0d: x=%0d primed=%b want x=%0d primed=%b",
                         i, col_x, primed, i % 8, (i >= 15));
            else pass_cnt++;
        end
        total_cnt++;
        if (col_valid !== 1'b1 || col_dout !== {8'd50, 8'd58, 8'd66})
            $display("FAIL maxlen_col: valid=%b got %h want 1 323a42", col_valid, col_dout);
        else pass_cnt++;
    endtask

    task automatic test_overrun();
        logic [23:0] ed;
        drive(1'b1, 1'b0, 8'd0, 3'd3);
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1, 8'(20 + i), 3'd0);
            total_cnt++;
            if (col_valid !== (i >= 6))
                $display("FAIL overrun_valid px%0d: got %b want %b", i, col_valid, (i >= 6));
            else pass_cnt++;
            if (i >= 6) begin
                ed = {8'(14 + i), 8'(17 + i), 8'(20 + i)};
                total_cnt++;
                if (col_dout !== ed || col_x !== 3'(i % 3))
                    $display("FAIL overrun_col px%0d: got %h x=%0d want %h x=%0d",
                             i, col_dout, col_x, ed, i % 3);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 8'd0, 3'd4);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'(i), 3'd0);
        total_cnt++;
        if (col_valid !== 1'b1 || primed !== 1'b1 || col_x !== 3'd1)
            $display("FAIL areset_pre: valid=%b primed=%b x=%0d want 1 1 1", col_valid, primed, col_x);
        else pass_cnt++;
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (col_valid !== 1'b0 || primed !== 1'b0 || col_x !== 3'd0 || col_dout !== 24'd0)
            $display("FAIL areset_async: valid=%b primed=%b x=%0d dout=%h want 0 0 0 000000",
                     col_valid, primed, col_x, col_dout);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // no sof after reset: line length defaults to the maximum of 8
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 8'(i), 3'd0);
        total_cnt++;
        if (col_x !== 3'd0 || primed !== 1'b0 || col_valid !== 1'b0)
            $display("FAIL areset_default_len: x=%0d primed=%b valid=%b want 0 0 0",
                     col_x, primed, col_valid);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        sof       = 1'b0;
        din_valid = 1'b0;
        din       = 8'd0;
        line_len  = 3'd0;
        test_reset();
        test_stream(0);
        test_stream(2);
        test_sof_midline();
        test_max_len();
        test_overrun();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
